prbs_step_controller: RTL
=========================

# prbs_step_controller

Sequences the 7-bit PRBS-to-seven-segment display path on the DE1-SoC. Turns a slide switch and a push-button into a one-cycle advance-enable for the PRBS generator: free-running at a programmable rate, or single-stepped per key press. Also blanks both displays until the first value has been requested. Sits between the board I/O and the PRBS/display top, which gates its PRBS register with `o_prbsStep` and its segment outputs with `o_blank`.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `STEP_HZ`, default 2: free-run step rate. `STEP_DIV = CLK_HZ/STEP_HZ` (integer, ≥2).
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a key level (≥1).

Ports (clock and reset first):
- `i_clk` input 1: single clock domain.
- `i_arst` input 1: reset, asynchronous and active-low.
- `i_runSwitch` input 1: slide switch, asynchronous; 1 = free-run.
- `i_stepKey_n` input 1: KEY push-button, asynchronous, active-low (0 = pressed).
- `o_prbsStep` output 1: one-cycle advance-enable to the PRBS.
- `o_blank` output 1: 1 = displays off.
- `o_running` output 1: 1 while in RUN.
- `o_stepCount` output 16: number of `o_prbsStep` pulses issued since reset.

## Operation
- Input conditioning:
  - Both inputs pass through 2-flop synchronisers.
  - The synchronised key is inverted to active-high.
  - The synchronised key is debounced: the accepted level changes only after the synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any glitch restarts the count.
  - A press event is a 0→1 transition of the accepted level. A release generates nothing.
- Rate counter: width `$clog2(STEP_DIV)`.
  - Counts only in RUN and wraps from `STEP_DIV-1` to 0.
  - Terminal count requests a step.
  - Cleared to 0 on every entry to RUN and whenever not in RUN.
- FSM states:
  - BLANK (reset state): `o_blank`=1, no steps.
    - Press → PAUSE with one step request.
    - runSwitch=1 → RUN.
  - PAUSE: `o_blank`=0.
    - Press → one step request, stay in PAUSE.
    - runSwitch=1 → RUN.
  - RUN: `o_blank`=0, `o_running`=1.
    - Step request at each rate terminal count.
    - Presses are ignored.
    - runSwitch=0 → PAUSE.
- Priority: if runSwitch=1 and a press occur in the same cycle in BLANK or PAUSE, go to RUN and drop the press.
- BLANK is re-entered only by reset.
- `o_prbsStep`: registered step request, never high on two consecutive cycles.
- `o_stepCount`: increments on every `o_prbsStep` cycle; wraps 0xFFFF→0x0000.
- Reset mid-operation: all state, counters, synchronisers and debounce clear immediately. A held key must be released and re-pressed after reset deassertion to register.

## Timing
- Reset values:
  - `o_prbsStep`=0, `o_blank`=1, `o_running`=0, `o_stepCount`=0.
  - Synchronisers, rate counter and debounce counter 0; accepted key level 0 (released).
  - State BLANK.
- Reset deassertion is synchronised externally. The first functional edge is the first `i_clk` rise after `i_arst` goes high.
- Key latency: with raw press stable from edge 0, the synchronised level is visible at edge 2. The accepted level rises at edge `2+DEBOUNCE_CYCLES`. `o_prbsStep` is high for the cycle after edge `3+DEBOUNCE_CYCLES`, and `o_stepCount` updates on the following edge.
- Switch latency: `i_runSwitch` rising at edge 0 gives the synchronised level at edge 2 and `o_running`=1 after edge 3.
- First free-run pulse: `STEP_DIV` cycles after RUN entry; thereafter exactly every `STEP_DIV` cycles.
- `o_blank` falls on the same edge that PAUSE or RUN is entered.

## Configuration
- `PRBS_STEP_CTRL_DEBOUNCE_EN`:
  - Defined: debouncer present as described.
  - Undefined: debouncer removed; the accepted key level equals the synchronised level, so key latency becomes press at edge 0 → `o_prbsStep` after edge 3. `DEBOUNCE_CYCLES` is ignored.

## Test plan
Parameters: `CLK_HZ`=100, `STEP_HZ`=10 (`STEP_DIV`=10), `DEBOUNCE_CYCLES`=4, macro defined unless stated.
1. Reset, idle 50 cycles → `o_blank`=1, `o_prbsStep` never high, `o_stepCount`=0.
2. Press key clean for 20 cycles → exactly one `o_prbsStep` pulse, 7 cycles after press. Then `o_blank`=0, `o_stepCount`=1, state PAUSE. Release and press again → `o_stepCount`=2.
3. Key bouncing 1/0 every 2 cycles for 20 cycles, then held → exactly one pulse, arriving 4 stable cycles plus pipeline after bouncing stops. With the macro undefined the same stimulus gives multiple pulses.
4. runSwitch=1 for 105 cycles after RUN entry → pulses at RUN-entry+10, +20 … (10 pulses). Key presses during RUN → no extra pulses. runSwitch=0 → `o_running`=0, pulses stop.
5. runSwitch rise and debounced press in the same cycle from PAUSE → RUN, no immediate extra pulse, first pulse after 10 cycles.
6. Assert `i_arst` mid-RUN with key held, then release reset → all outputs at reset values, state BLANK. No pulse until the key is released and re-pressed. After 65536 total steps `o_stepCount` wraps to 0.

Source files
------------

// File: rtl/prbs_step_controller.sv
// Run/step sequencer for the PRBS seven-segment path: conditions switch and key, issues advance pulses.
// Define PRBS_STEP_CTRL_DEBOUNCE_EN to build in the key debouncer; without it the synchronised key is used directly.
//
// state    | meaning
// ST_BLANK | after reset, displays off, waiting for first press or run
// ST_PAUSE | displays on, one step per key press
// ST_RUN   | displays on, free-running at STEP_DIV cycles per step
module prbs_step_controller #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int STEP_HZ         = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_runSwitch,
    input  logic        i_stepKey_n,
    output logic        o_prbsStep,
    output logic        o_blank,
    output logic        o_running,
    output logic [15:0] o_stepCount
);

    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int RATE_W   = $clog2(STEP_DIV);

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    if (STEP_DIV < 2) begin : g_chk_step_div
        $error("prbs_step_controller: CLK_HZ/STEP_HZ must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("prbs_step_controller: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0]        run_sync;
    logic [1:0]        key_sync;
    logic [1:0]        sync_vld;
    logic              run_s;
    logic              key_s;
    logic              key_lvl;
    logic              key_lvl_q;
    logic              key_armed;
    logic              press_evt;
    logic [RATE_W-1:0] rate_cnt;
    logic              rate_tc;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              step_req;
    logic [15:0]       step_cnt;

    // Key is inverted ahead of the synchroniser so the cleared flops read as "released".
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            run_sync <= '0;
            key_sync <= '0;
            sync_vld <= '0;
        end else begin
            run_sync <= {run_sync[0], i_runSwitch};
            key_sync <= {key_sync[0], ~i_stepKey_n};
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign run_s = run_sync[1];
    assign key_s = key_sync[1];

`ifdef PRBS_STEP_CTRL_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            db_cnt  <= '0;
            key_lvl <= 1'b0;
        end else if (key_s == key_lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_lvl <= key_s;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    assign key_lvl = key_s;
`endif

    // A key already held when reset lifts must be seen released once before presses count.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            key_lvl_q <= 1'b0;
            key_armed <= 1'b0;
        end else begin
            key_lvl_q <= key_lvl;
            if (sync_vld[1] && !key_s) begin
                key_armed <= 1'b1;
            end
        end
    end

    assign press_evt = key_lvl && !key_lvl_q && key_armed;
    assign rate_tc   = (rate_cnt == RATE_W'(STEP_DIV - 1));

    always_comb begin
        state_nxt = state;
        step_req  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (run_s) begin
                    state_nxt = ST_RUN;
                end else if (press_evt) begin
                    state_nxt = ST_PAUSE;
                    step_req  = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (run_s) begin
                    state_nxt = ST_RUN;
                end else if (press_evt) begin
                    step_req = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_s) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    step_req = rate_tc;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state      <= ST_BLANK;
            o_prbsStep <= 1'b0;
            rate_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            o_prbsStep <= step_req;
            if (state == ST_RUN && run_s) begin
                rate_cnt <= rate_tc ? '0 : rate_cnt + RATE_W'(1);
            end else begin
                rate_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            step_cnt <= '0;
        end else if (o_prbsStep) begin
            step_cnt <= step_cnt + 16'd1;
        end
    end

    assign o_blank     = (state == ST_BLANK);
    assign o_running   = (state == ST_RUN);
    assign o_stepCount = step_cnt;

endmodule
